// File: rtl/dp_mem_pkg.sv
// Shared types and constants for the dual-port byte-strobed memory.
package dp_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/dp_mem_array.sv
// DEPTH x DW storage: one byte-strobed write port, one registered read port.
module dp_mem_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 4096,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IW-1:0]   w_idx,
    input  logic [DW-1:0]   w_data,
    input  logic [DW/8-1:0] w_strb,
    input  logic            re,
    input  logic [IW-1:0]   r_idx,
    output logic [DW-1:0]   r_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] r_data_reg;

    // Read returns the pre-write contents; same-word forwarding is done by the caller.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (w_strb[b]) begin
                    mem[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
                end
            end
        end
        if (re) begin
            r_data_reg <= mem[r_idx];
        end
    end

    assign r_data = r_data_reg;

endmodule

// File: rtl/dp_mem.sv
// Byte-addressed memory with power-up zero fill, write-first forwarding and 1/2-cycle read latency.
module dp_mem
    import dp_mem_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int DEPTH      = 4096,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wen,
    input  logic [AW-1:0]   w_addr,
    input  logic [DW-1:0]   w_data,
    input  logic [DW/8-1:0] w_strb,
    input  logic            ren,
    input  logic [AW-1:0]   r_addr,
    output logic [DW-1:0]   r_data,
    output logic            r_valid,
    output logic            busy
);

    localparam int NB  = DW / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);

    state_t        state_reg;
    logic [IW-1:0] cnt_reg;
    logic          busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= (INIT_CLEAR != 0) ? CLEAR : READY;
            busy_reg  <= (INIT_CLEAR != 0);
            cnt_reg   <= '0;
        end else if (state_reg == CLEAR) begin
            if (cnt_reg == IW'(DEPTH - 1)) begin
                state_reg <= READY;
                busy_reg  <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign busy = busy_reg;

    // Word decode: an index at or beyond DEPTH is out of range.
    logic [AW-1:0] w_word, r_word;
    logic          w_ok, r_ok;
    logic [IW-1:0] w_idx, r_idx;

    assign w_word = w_addr >> OFF;
    assign r_word = r_addr >> OFF;
    assign w_ok   = (w_word < AW'(DEPTH));
    assign r_ok   = (r_word < AW'(DEPTH));
    assign w_idx  = w_word[IW-1:0];
    assign r_idx  = r_word[IW-1:0];

    logic wr_acc, rd_acc;
    assign wr_acc = !rst && !busy_reg && wen && w_ok;
    assign rd_acc = !rst && !busy_reg && ren;

    logic            arr_we;
    logic [IW-1:0]   arr_widx;
    logic [DW-1:0]   arr_wdata;
    logic [NB-1:0]   arr_wstrb;
    logic [DW-1:0]   mem_q;

    assign arr_we    = busy_reg || wr_acc;
    assign arr_widx  = busy_reg ? cnt_reg : w_idx;
    assign arr_wdata = busy_reg ? '0 : w_data;
    assign arr_wstrb = busy_reg ? '1 : w_strb;

    dp_mem_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .w_idx  (arr_widx),
        .w_data (arr_wdata),
        .w_strb (arr_wstrb),
        .re     (rd_acc),
        .r_idx  (r_idx),
        .r_data (mem_q)
    );

    // Stage 1: remember which bytes of a same-cycle write must override the array read.
    logic          v1_reg, oor1_reg;
    logic [NB-1:0] fwd_strb_reg;
    logic [DW-1:0] fwd_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg       <= 1'b0;
            oor1_reg     <= 1'b0;
            fwd_strb_reg <= '0;
            fwd_data_reg <= '0;
        end else begin
            v1_reg <= rd_acc;
            if (rd_acc) begin
                oor1_reg     <= !r_ok;
                fwd_strb_reg <= (wr_acc && (w_idx == r_idx)) ? w_strb : '0;
                fwd_data_reg <= w_data;
            end
        end
    end

    logic [DW-1:0] merged;

    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
        assign merged[gi*8 +: 8] = oor1_reg        ? 8'h00 :
                                   fwd_strb_reg[gi] ? fwd_data_reg[gi*8 +: 8] :
                                                      mem_q[gi*8 +: 8];
    end

    if (RD_LAT == RD_LAT_MAX) begin : g_lat2
        logic          v2_reg;
        logic [DW-1:0] d2_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                v2_reg <= 1'b0;
                d2_reg <= '0;
            end else begin
                v2_reg <= v1_reg;
                if (v1_reg) begin
                    d2_reg <= merged;
                end
            end
        end

        assign r_valid = v2_reg;
        assign r_data  = d2_reg;
    end else begin : g_lat1
        logic [DW-1:0] hold_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_reg <= '0;
            end else if (v1_reg) begin
                hold_reg <= merged;
            end
        end

        assign r_valid = v1_reg;
        assign r_data  = v1_reg ? merged : hold_reg;
    end

endmodule

// File: tb/tb_dp_mem.sv
// Two dp_mem instances (RD_LAT 1 and 2) driven in lockstep and compared against a word-level model.
module tb_dp_mem;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b0;
    logic [31:0] w_addr = '0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        ren = 1'b0;
    logic [31:0] r_addr = '0;

    logic [31:0] r_data1, r_data2;
    logic        r_valid1, r_valid2, busy1, busy2;

    always #5 clk = ~clk;

    dp_mem #(.DW(32), .AW(32), .DEPTH(DEPTH), .RD_LAT(1), .INIT_CLEAR(1)) u_dut1 (
        .clk(clk), .rst(rst), .wen(wen), .w_addr(w_addr), .w_data(w_data), .w_strb(w_strb),
        .ren(ren), .r_addr(r_addr), .r_data(r_data1), .r_valid(r_valid1), .busy(busy1)
    );

    dp_mem #(.DW(32), .AW(32), .DEPTH(DEPTH), .RD_LAT(2), .INIT_CLEAR(1)) u_dut2 (
        .clk(clk), .rst(rst), .wen(wen), .w_addr(w_addr), .w_data(w_data), .w_strb(w_strb),
        .ren(ren), .r_addr(r_addr), .r_data(r_data2), .r_valid(r_valid2), .busy(busy2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (strb[b]) res[b*8 +: 8] = nw[b*8 +: 8];
        return res;
    endfunction

    // Word-level model: contents, remaining clear cycles, and expected outputs per latency.
    logic [31:0] mem_m [DEPTH];
    int          clear_left = 0;
    bit          started = 0;
    logic        e1_v = 0, e2_v = 0, p2_v = 0;
    logic [31:0] e1_d = '0, e2_d = '0, p2_d = '0;

    always @(posedge clk) begin
        logic [31:0] rword, wword, val;
        logic        acc, wacc;
        if (rst) begin
            started    = 1;
            clear_left = DEPTH;
            p2_v = 0; e1_v = 0; e2_v = 0;
            e1_d = '0; e2_d = '0;
        end else begin
            rword = r_addr >> 2;
            wword = w_addr >> 2;
            acc   = (clear_left == 0) && ren;
            wacc  = (clear_left == 0) && wen && (wword < DEPTH);
            if (rword >= DEPTH) val = '0;
            else begin
                val = mem_m[rword[5:0]];
                if (wacc && wword == rword) val = merge(val, w_data, w_strb);
            end
            e1_v = acc;  if (acc)  e1_d = val;
            e2_v = p2_v; if (p2_v) e2_d = p2_d;
            p2_v = acc;  p2_d = val;
            if (clear_left > 0) begin
                mem_m[DEPTH - clear_left] = '0;
                clear_left--;
            end else if (wacc) begin
                mem_m[wword[5:0]] = merge(mem_m[wword[5:0]], w_data, w_strb);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("busy1", {31'b0, busy1}, {31'b0, clear_left > 0});
            check("busy2", {31'b0, busy2}, {31'b0, clear_left > 0});
            check("valid1", {31'b0, r_valid1}, {31'b0, e1_v});
            check("valid2", {31'b0, r_valid2}, {31'b0, e2_v});
            check("data1", r_data1, e1_d);
            check("data2", r_data2, e2_d);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wen = 1; w_addr = a; w_data = d; w_strb = s;
        cyc();
        wen = 0;
    endtask

    task automatic read_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
        ren = 1; r_addr = a;
        cyc();
        ren = 0;
        check({name, "_v1"}, {31'b0, r_valid1}, 32'd1);
        check({name, "_d1"}, r_data1, exp);
        cyc();
        check({name, "_v2"}, {31'b0, r_valid2}, 32'd1);
        check({name, "_d2"}, r_data2, exp);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy1 && n < 1000) begin
            n++;
            cyc();
        end
    endtask

    task automatic random_traffic(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            logic [31:0] wi, ri;
            wi = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH + 3);
            ri = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH + 3);
            wen    = ($urandom_range(0, 2) != 0);
            ren    = ($urandom_range(0, 2) != 0);
            w_addr = (wi << 2) | 32'($urandom_range(0, 3));
            r_addr = (ri << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) w_addr = $urandom;
            if ($urandom_range(0, 15) == 0) r_addr = $urandom;
            w_data = $urandom;
            w_strb = 4'($urandom_range(0, 15));
            cyc();
        end
        wen = 0; ren = 0;
    endtask

    initial begin
        int n;
        cyc();
        cyc();
        check("rst_busy", {31'b0, busy1}, 32'd1);
        check("rst_valid", {31'b0, r_valid2}, 32'd0);
        check("rst_data1", r_data1, 32'd0);
        check("rst_data2", r_data2, 32'd0);
        rst = 0;
        count_busy(n);
        check("clear_len", n, DEPTH);

        for (int w = 0; w < DEPTH; w++) read_lit("zero", 32'(w) << 2, 32'h0);

        do_write(32'h40, 32'hDEADBEEF, 4'b1111);
        do_write(32'h40, 32'h11223344, 4'b0101);
        read_lit("strb", 32'h40, 32'hDE22BE44);

        // Same-cycle write and read of one word returns the new bytes.
        wen = 1; w_addr = 32'h80; w_data = 32'hCAFEF00D; w_strb = 4'hF;
        ren = 1; r_addr = 32'h80;
        cyc();
        wen = 0; ren = 0;
        check("wfirst_d1", r_data1, 32'hCAFEF00D);
        cyc();
        check("wfirst_d2", r_data2, 32'hCAFEF00D);

        // A write one cycle after a read must not leak into that read.
        do_write(32'h10, 32'hA5A5A5A5, 4'hF);
        ren = 1; r_addr = 32'h10;
        cyc();
        ren = 0;
        wen = 1; w_addr = 32'h10; w_data = 32'h0; w_strb = 4'hF;
        check("rtw_d1", r_data1, 32'hA5A5A5A5);
        cyc();
        wen = 0;
        check("rtw_v2", {31'b0, r_valid2}, 32'd1);
        check("rtw_d2", r_data2, 32'hA5A5A5A5);
        read_lit("rtw_after", 32'h10, 32'h0);

        read_lit("oor_rd", 32'(DEPTH) << 2, 32'h0);
        do_write(32'(DEPTH) << 2, 32'hFFFFFFFF, 4'hF);
        read_lit("oor_w0", 32'h0, 32'h0);
        read_lit("oor_w40", 32'h40, 32'hDE22BE44);

        random_traffic(800);

        // A read accepted just before reset must not emerge from the 2-cycle pipe.
        ren = 1; r_addr = 32'h40;
        cyc();
        ren = 0; rst = 1;
        cyc();
        check("flush_v1", {31'b0, r_valid1}, 32'd0);
        check("flush_v2", {31'b0, r_valid2}, 32'd0);
        check("flush_d2", r_data2, 32'd0);
        rst = 0;

        // Reset in the middle of the fill restarts it from word 0.
        for (int i = 0; i < 7; i++) cyc();
        check("mid_busy", {31'b0, busy1}, 32'd1);
        rst = 1;
        cyc();
        check("restart_busy", {31'b0, busy1}, 32'd1);
        rst = 0;
        count_busy(n);
        check("restart_len", n, DEPTH);
        read_lit("after_clr", 32'h40, 32'h0);

        random_traffic(400);
        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dp_mem.md
DP_MEM -- requirements
Module: dp_mem

Interface
REQ-001 Parameter DW, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 32: byte-address width.
REQ-003 Parameter DEPTH, default 4096: number of DW-bit words; SHALL be a power of two.
REQ-004 Parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-005 Parameter INIT_CLEAR, default 1: 1 = zero-fill the array after reset; 0 = no fill.
REQ-006 Reset: one clock; synchronous, active-high reset.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 wen  in  1  write request.
REQ-010 w_addr  in  AW  byte address of the write.
REQ-011 w_data  in  DW  write data.
REQ-012 w_strb  in  DW/8  byte enables; bit i gates w_data[8i+7:8i].
REQ-013 ren  in  1  read request.
REQ-014 r_addr  in  AW  byte address of the read.
REQ-015 r_data  out  DW  read data.
REQ-016 r_valid  out  1  one-cycle pulse qualifying r_data.
REQ-017 busy  out  1  high while the clear sequence runs; requests ignored.

Function
REQ-018 Word index SHALL be addr[AW-1:log2(DW/8)]; low byte-offset bits are ignored.
REQ-019 A word index >= DEPTH SHALL be out of range: the write is dropped; the read returns all-zero data with r_valid still asserted.
REQ-020 A write with wen=1 and busy=0 SHALL update only the bytes whose w_strb bit is 1, at the clock edge; w_strb=0 is a no-op.
REQ-021 A read accepted in cycle N (ren=1, busy=0) SHALL assert r_valid and present r_data in cycle N+RD_LAT; back-to-back reads SHALL each produce a result (throughput 1 per cycle).
REQ-022 Read and write in the same cycle to the same word SHALL be write-first: r_data = old word merged with strobed new bytes.
REQ-023 With RD_LAT=2, a write in cycle N+1 to the word read in cycle N SHALL NOT alter that read's result (read-then-write order).
REQ-024 r_data SHALL hold its last value when r_valid=0.
REQ-025 Control FSM states: CLEAR, READY. Reset enters CLEAR if INIT_CLEAR=1, else READY.
REQ-026 CLEAR: busy=1; a counter writes zero to word 0, 1, ... DEPTH-1, one per cycle; after the write of word DEPTH-1, the FSM moves to READY in the next cycle. CLEAR therefore lasts exactly DEPTH cycles.
REQ-027 In CLEAR, wen and ren SHALL be ignored; no r_valid is generated.
REQ-028 READY is terminal until rst; busy=0.
REQ-029 Reads accepted before rst SHALL be discarded: no r_valid after a reset edge.

Reset
REQ-030 On rst: r_valid=0, r_data=0, read pipeline flushed, clear counter=0, busy=INIT_CLEAR.
REQ-031 rst during CLEAR SHALL restart the fill from word 0.
REQ-032 With INIT_CLEAR=0, array contents SHALL be unaffected by rst.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (CLEAR, READY) and the legal RD_LAT constants.
REQ-034 The storage array SHALL be a sub-module dp_mem_array: DEPTH x DW, one strobed write port, one synchronous read port; dp_mem holds the FSM, forwarding and latency pipeline.
REQ-035 Out-of-range decode, write-first merge and the RD_LAT=2 output register SHALL reside in dp_mem.

Verification
REQ-036 INIT_CLEAR=1, DEPTH=16: release rst -> busy=1 for exactly 16 cycles; then reads of words 0..15 return 0x00000000.
REQ-037 Write 0xDEADBEEF to 0x40 with strb=4'b1111, then write 0x11223344 to 0x40 with strb=4'b0101; read 0x40 -> 0xDE22BE44 valid RD_LAT cycles later.
REQ-038 Same cycle: write 0xCAFEF00D (strb all ones) and read address 0x80, whose old value is 0 -> r_data=0xCAFEF00D.
REQ-039 RD_LAT=2: read 0x10 (value 0xA5A5A5A5) in cycle N, write 0x0 to 0x10 in N+1 -> r_valid in N+2 with 0xA5A5A5A5.
REQ-040 Read of word index DEPTH -> r_valid=1 with r_data=0; write of word index DEPTH leaves all words unchanged.
REQ-041 Assert rst at clear-counter value 7 -> busy stays 1; the fill restarts at word 0 and runs a full DEPTH cycles; a read issued just before rst produces no r_valid.
